alut_age_scan13: RTL and testbench

ALUT_AGE_SCAN13 -- requirements
Module: alut_age_scan13

---
 rtl/alut_age_scan13.sv | 152 +++++++++++++++
 tb/tb_alut_age_scan13.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alut_age_scan13.sv
// Address-table age scanner: walks every entry of the table once per start13
// request and clears the valid bit of any entry older than age_thresh13.
//
// Ports
//   pclk13               in   clock, rising edge
//   p_reset13            in   synchronous active-high reset
//   start13              in   one-cycle scan request (honoured only in IDLE)
//   curr_time13          in   free-running time base
//   age_thresh13         in   maximum allowed entry age
//   add_busy13           in   add port owns the table; scanner stalls
//   mem_read_data_age13  in   age-port read data, one cycle after the address
//   mem_addr_age13       out  age-port address
//   mem_write_age13      out  age-port write strobe
//   mem_write_data_age13 out  age-port write data, zero when not writing
//   busy13               out  scan in progress
//   done13               out  one-cycle pulse at the end of a scan
//   aged_count13         out  entries invalidated by the last/current scan
//
// Entry layout: [DW13-1] valid, [DW13-2 -: 32] timestamp, then port and MAC.

module alut_age_scan13 #(
    parameter int DW13 = 83,
    parameter int DD13 = 256
) (
    input  logic            pclk13,
    input  logic            p_reset13,
    input  logic            start13,
    input  logic [31:0]     curr_time13,
    input  logic [31:0]     age_thresh13,
    input  logic            add_busy13,
    input  logic [DW13-1:0] mem_read_data_age13,
    output logic [7:0]      mem_addr_age13,
    output logic            mem_write_age13,
    output logic [DW13-1:0] mem_write_data_age13,
    output logic            busy13,
    output logic            done13,
    output logic [8:0]      aged_count13
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DD13 - 1);

    state_t          state;
    logic [7:0]      idx;
    logic [DW13-1:0] wdata;
    logic            busy_q;
    logic            done_q;
    logic [8:0]      aged_cnt;

    // Field extraction from the entry returned by the memory.
    logic            ent_valid;
    logic [31:0]     ent_ts;
    logic [31:0]     ent_age;
    logic            ent_aged;
    logic            last_idx;
    logic            wr_go;

    assign ent_valid = mem_read_data_age13[DW13-1];
    assign ent_ts    = mem_read_data_age13[DW13-2 -: 32];
    // Unsigned subtraction wraps mod 2^32, so a time base that rolled over
    // since the entry was stamped still yields the true age.
    assign ent_age   = curr_time13 - ent_ts;
    assign ent_aged  = ent_valid && (ent_age > age_thresh13);
    assign last_idx  = (idx == LAST_IDX);

    // The write strobe is gated with add_busy13 in the same cycle so the
    // scanner can never collide with the add port on the shared table.
    assign wr_go = (state == WRITE) && !add_busy13;

    always_ff @(posedge pclk13) begin
        if (p_reset13) begin
            state    <= IDLE;
            idx      <= '0;
            wdata    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            aged_cnt <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start13) begin
                        aged_cnt <= '0;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= READ;
                    end
                end

                READ: begin
                    if (!add_busy13) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (ent_aged) begin
                        wdata <= {1'b0, mem_read_data_age13[DW13-2:0]};
                        state <= WRITE;
                    end else if (last_idx) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end

                WRITE: begin
                    if (!add_busy13) begin
                        aged_cnt <= aged_cnt + 9'd1;
                        wdata    <= '0;
                        if (last_idx) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= READ;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Address is only meaningful while scanning; park it at 0 otherwise.
    assign mem_addr_age13       = busy_q ? idx : 8'd0;
    assign mem_write_age13      = wr_go;
    assign mem_write_data_age13 = wr_go ? wdata : '0;
    assign busy13               = busy_q;
    assign done13               = done_q;
    assign aged_count13         = aged_cnt;

endmodule

// File: tb/tb_alut_age_scan13.sv
// Scoreboard bench for alut_age_scan13: stimulus queues expected writes and
// scan completions, a negedge monitor pops and compares them.

module tb_alut_age_scan13;

    localparam int DW = 83;
    localparam int DD = 256;

    logic          pclk13 = 1'b0;
    logic          p_reset13;
    logic          start13;
    logic [31:0]   curr_time13;
    logic [31:0]   age_thresh13;
    logic          add_busy13;
    logic [DW-1:0] rdata;
    logic [7:0]    mem_addr_age13;
    logic          mem_write_age13;
    logic [DW-1:0] mem_write_data_age13;
    logic          busy13;
    logic          done13;
    logic [8:0]    aged_count13;

    alut_age_scan13 #(.DW13(DW), .DD13(DD)) dut (
        .pclk13               (pclk13),
        .p_reset13            (p_reset13),
        .start13              (start13),
        .curr_time13          (curr_time13),
        .age_thresh13         (age_thresh13),
        .add_busy13           (add_busy13),
        .mem_read_data_age13  (rdata),
        .mem_addr_age13       (mem_addr_age13),
        .mem_write_age13      (mem_write_age13),
        .mem_write_data_age13 (mem_write_data_age13),
        .busy13               (busy13),
        .done13               (done13),
        .aged_count13         (aged_count13)
    );

    always #5 pclk13 = ~pclk13;

    int cyc = 0;
    always @(posedge pclk13) cyc <= cyc + 1;

    // Table model with registered read; the bench loads it through tb_* ports.
    logic [DW-1:0] mem [DD];
    logic          tb_we;
    logic          tb_clr;
    logic [7:0]    tb_wa;
    logic [DW-1:0] tb_wd;

    always @(posedge pclk13) begin
        rdata <= mem[mem_addr_age13];
        if (tb_clr) begin
            for (int i = 0; i < DD; i++) mem[i] <= '0;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (mem_write_age13) begin
            mem[mem_addr_age13] <= mem_write_data_age13;
        end
    end

    typedef struct {
        logic [7:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int cnt;
        int lat;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  checks = 0;
    int  errors = 0;
    int  start_edge = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] mk(logic v, logic [31:0] ts,
                                         logic [1:0] port, logic [47:0] mac);
        return {v, ts, port, mac};
    endfunction

    // Monitor
    always @(negedge pclk13) begin
        chk("wr_vs_add_busy", 128'(mem_write_age13 && add_busy13), 128'd0);
        if (!mem_write_age13)
            chk("wdata_idle_zero", 128'(mem_write_data_age13), 128'd0);
        if (mem_write_age13) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write_addr", 128'(mem_addr_age13), 128'hFFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("write_addr", 128'(mem_addr_age13), 128'(e.a));
                chk("write_data", 128'(mem_write_data_age13), 128'(e.d));
            end
        end
        if (done13) begin
            if (dn_q.size() == 0) begin
                chk("unexpected_done", 128'd1, 128'd0);
            end else begin
                dn_t e;
                e = dn_q.pop_front();
                chk("aged_count", 128'(aged_count13), 128'(e.cnt));
                chk("done_latency", 128'(cyc - start_edge + 1), 128'(e.lat));
            end
        end
    end

    task automatic set_entry(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge pclk13);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge pclk13);
        tb_we = 1'b0;
    endtask

    task automatic clear_all();
        @(negedge pclk13);
        tb_clr = 1'b1;
        @(negedge pclk13);
        tb_clr = 1'b0;
    endtask

    task automatic do_start();
        @(negedge pclk13);
        start13    = 1'b1;
        start_edge = cyc + 1;
        @(negedge pclk13);
        start13 = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done13 && n < budget) begin
            @(negedge pclk13);
            n++;
        end
        if (!done13) chk("done_timeout", 128'd0, 128'd1);
        @(negedge pclk13);
    endtask

    initial begin
        p_reset13    = 1'b1;
        start13      = 1'b0;
        add_busy13   = 1'b0;
        curr_time13  = 32'd300;
        age_thresh13 = 32'd150;
        tb_we        = 1'b0;
        tb_wa        = '0;
        tb_wd        = '0;
        tb_clr       = 1'b1;
        repeat (3) @(negedge pclk13);
        tb_clr = 1'b0;
        chk("rst_busy", 128'(busy13), 128'd0);
        chk("rst_done", 128'(done13), 128'd0);
        chk("rst_count", 128'(aged_count13), 128'd0);
        chk("rst_addr", 128'(mem_addr_age13), 128'd0);
        chk("rst_write", 128'(mem_write_age13), 128'd0);
        p_reset13 = 1'b0;
        @(negedge pclk13);

        // All entries invalid: no writes, 513-cycle scan.
        dn_q.push_back('{0, 513});
        do_start();
        chk("busy_in_scan", 128'(busy13), 128'd1);
        wait_done(2000);
        chk("busy_after", 128'(busy13), 128'd0);

        // Entry 5 aged: age 200 > 150.
        set_entry(8'd5, mk(1'b1, 32'd100, 2'd2, 48'hA));
        wr_q.push_back('{8'd5, mk(1'b0, 32'd100, 2'd2, 48'hA)});
        dn_q.push_back('{1, 514});
        do_start();
        wait_done(2000);
        chk("count_hold", 128'(aged_count13), 128'd1);

        // Same entry, age equals threshold: not aged.
        set_entry(8'd5, mk(1'b1, 32'd100, 2'd2, 48'hA));
        age_thresh13 = 32'd200;
        dn_q.push_back('{0, 513});
        do_start();
        wait_done(2000);

        // Time base wrapped: age 0x20 > 0x10.
        clear_all();
        set_entry(8'd7, mk(1'b1, 32'hFFFF_FFF0, 2'd1, 48'h1234));
        curr_time13  = 32'h10;
        age_thresh13 = 32'h10;
        wr_q.push_back('{8'd7, mk(1'b0, 32'hFFFF_FFF0, 2'd1, 48'h1234)});
        dn_q.push_back('{1, 514});
        do_start();
        wait_done(2000);

        // Last entry aged, add port busy for 4 cycles while in WRITE.
        clear_all();
        curr_time13  = 32'd300;
        age_thresh13 = 32'd150;
        set_entry(8'd255, mk(1'b1, 32'd100, 2'd2, 48'hA));
        wr_q.push_back('{8'd255, mk(1'b0, 32'd100, 2'd2, 48'hA)});
        dn_q.push_back('{1, 518});
        do_start();
        begin
            int n = 0;
            while (cyc != start_edge + 512 && n < 2000) begin
                @(negedge pclk13);
                n++;
            end
        end
        add_busy13 = 1'b1;
        repeat (4) @(negedge pclk13);
        add_busy13 = 1'b0;
        wait_done(100);

        // Reset mid-scan at index 100, with start13 held during reset.
        clear_all();
        set_entry(8'd3, mk(1'b1, 32'd100, 2'd0, 48'h3));
        set_entry(8'd150, mk(1'b1, 32'd100, 2'd3, 48'h150));
        wr_q.push_back('{8'd3, mk(1'b0, 32'd100, 2'd0, 48'h3)});
        do_start();
        begin
            int n = 0;
            while (mem_addr_age13 != 8'd100 && n < 2000) begin
                @(negedge pclk13);
                n++;
            end
        end
        chk("reached_idx100", 128'(mem_addr_age13), 128'd100);
        p_reset13 = 1'b1;
        start13   = 1'b1;
        @(negedge pclk13);
        p_reset13 = 1'b0;
        start13   = 1'b0;
        chk("midrst_busy", 128'(busy13), 128'd0);
        chk("midrst_count", 128'(aged_count13), 128'd0);
        chk("midrst_addr", 128'(mem_addr_age13), 128'd0);
        @(negedge pclk13);
        chk("start_in_rst_ignored", 128'(busy13), 128'd0);
        wr_q.push_back('{8'd150, mk(1'b0, 32'd100, 2'd3, 48'h150)});
        dn_q.push_back('{1, 514});
        do_start();
        wait_done(2000);

        repeat (3) @(negedge pclk13);
        chk("writes_left", 128'(wr_q.size()), 128'd0);
        chk("dones_left", 128'(dn_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
